rcon_seq: RTL
=============

Name: rcon_seq

Overview:
- Sequential AES round-constant generator, replacing the static Rcon lookup ROM.
- Steps Rcon through GF(2^8) doubling (forward) or halving (reverse), so decryption key schedules get constants last-to-first.
- Sequence length follows the key size: AES-128 = 10, AES-192 = 8, AES-256 = 7.
- Sits between the key-expansion controller (consumer, valid/next handshake) and the SIMD key-schedule datapath.

Parameters:
- BITS, 32, output word width. Multiple of 8, >= 8. Rcon byte occupies [BITS-1:BITS-8]; lower bits are zero.
- IDX_BITS, 4, width of the round-index output. Must hold 10.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high; single clock domain (clk).
- start  input  1  begin a new sequence. Samples key_size and reverse.
- key_size  input  2  00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved (treated as 00).
- reverse  input  1  0 = ascending Rcon[1..N]; 1 = descending Rcon[N..1].
- next  input  1  consumer ready; a transfer happens when valid && next.
- valid  output  1  readData/index/last are valid.
- readData  output  BITS  {rcon, (BITS-8)'b0}.
- index  output  IDX_BITS  1-based round number of the current constant.
- last  output  1  current constant is the final one of the sequence.
- busy  output  1  sequence in progress (state RUN).
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal rcon register 8'h01.
- States:
  - IDLE: start -> RUN.
  - RUN: valid=1, busy=1. Transfer on the final element -> IDLE with done=1 on the next cycle.
- Latency: start sampled at edge k. valid=1 with the first constant from edge k+1. No bubbles between transfers: a transfer at edge j presents the next constant at edge j+1 output.
- N (sequence length): 10 / 8 / 7 per latched key_size.
- Forward (reverse=0):
  - Start value 8'h01, index=1.
  - Step: r' = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 8'h00); index+1.
- Reverse (reverse=1):
  - Start value Rcon[N]: 8'h36 (N=10), 8'h80 (N=8), 8'h40 (N=7); index=N.
  - Step: r' = (r >> 1) ^ (r[0] ? 8'h8D : 8'h00); index-1.
- last: high when index==N (forward) or index==1 (reverse), and only while valid.
- Holding: valid && !next holds readData, index and last stable indefinitely.
- start in RUN: aborts and restarts. New key_size/reverse are latched; the first constant appears the next cycle; no done pulse for the aborted sequence. start has priority over a simultaneous transfer.
- start in the same cycle done is asserted: legal; done still pulses.
- key_size/reverse changes outside a start cycle: ignored.
- rst mid-sequence: IDLE next cycle, all outputs 0, no done pulse.
- next while IDLE: ignored.

Optional Feature:
- Macro RCON_SEQ_ROM_EN.
- Defined: constants come from a 10-entry localparam table {01,02,04,08,10,20,40,80,1B,36}, indexed by index-1. The xtime/inverse-xtime logic is not instantiated.
- Undefined: arithmetic stepping as above.
- Cycle-exact identical outputs in both builds; the bench runs both.

Decomposition:
- Package aes_pkg:
  - key_size_t enum (AES128, AES192, AES256).
  - RCON_POLY = 8'h1B, RCON_INV_POLY = 8'h8D.
  - Function rcon_rounds(key_size_t) returning 10/8/7.
  - Function rcon_last(key_size_t) returning 36/80/40.
  - rcon_state_t enum (IDLE, RUN).
- Sub-module gf_xtime: combinational, input 8-bit r and dir, output next r. Excluded when RCON_SEQ_ROM_EN is defined.

Test Plan:
- AES-128 forward, next tied 1: start -> valid from the next cycle. readData = 01000000, 02000000 … 1B000000, 36000000 over 10 cycles; index 1..10; last only on 36; done one cycle after.
- AES-256 reverse: start with key_size=10, reverse=1 -> 40,20,10,08,04,02,01 (<<24). index 7..1; last on 01.
- Backpressure on AES-192 forward: next=0 for 5 cycles at index 4 -> readData holds 08000000, index=4. Resumes with 10,20,40,80; last on 80.
- Restart: start with key_size=00 after 3 transfers of an AES-128 sequence -> next cycle readData=01000000, index=1; no done pulse for the aborted run.
- Reset mid-run at index 6 -> next cycle valid=busy=done=0, readData=0. A following start produces the full sequence from 01.
- key_size=11 forward -> identical to AES-128 (10 constants, ending at 36). Repeat all cases with RCON_SEQ_ROM_EN defined and compare the traces cycle-for-cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and helpers for the round-constant sequencer.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128 = 2'b00,
    AES192 = 2'b01,
    AES256 = 2'b10
  } key_size_t;

  typedef enum logic {
    IDLE,
    RUN
  } rcon_state_t;

  // GF(2^8) reduction constant for doubling, and its counterpart for halving
  localparam logic [7:0] RCON_POLY     = 8'h1B;
  localparam logic [7:0] RCON_INV_POLY = 8'h8D;

  // The reserved encoding 2'b11 behaves as AES-128
  function automatic key_size_t decode_key_size(input logic [1:0] ks);
    case (ks)
      2'b01:   return AES192;
      2'b10:   return AES256;
      default: return AES128;
    endcase
  endfunction

  function automatic logic [3:0] rcon_rounds(input key_size_t ks);
    case (ks)
      AES192:  return 4'd8;
      AES256:  return 4'd7;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] rcon_last(input key_size_t ks);
    case (ks)
      AES192:  return 8'h80;
      AES256:  return 8'h40;
      default: return 8'h36;
    endcase
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Combinational GF(2^8) step: doubling (dir=0) or halving (dir=1) of a round constant.
module gf_xtime
  import aes_pkg::*;
(
  input  logic [7:0] r,
  input  logic       dir,
  output logic [7:0] r_next
);

  // Halving is the exact inverse of doubling under the AES polynomial
  always_comb begin
    r_next = 8'h00;
    if (!dir) begin
      r_next = {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
    end else begin
      r_next = {1'b0, r[7:1]} ^ (r[0] ? RCON_INV_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/rcon_seq.sv
// Sequential AES round-constant generator with a valid/next handshake.
// Build option: define RCON_SEQ_ROM_EN to source constants from a 10-entry table
// instead of GF(2^8) stepping; outputs are cycle-identical in both builds.
module rcon_seq
  import aes_pkg::*;
#(
  parameter int unsigned BITS     = 32,
  parameter int unsigned IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          key_size,
  input  logic                reverse,
  input  logic                next,
  output logic                valid,
  output logic [BITS-1:0]     readData,
  output logic [IDX_BITS-1:0] index,
  output logic                last,
  output logic                busy,
  output logic                done
);

  rcon_state_t         state_q, state_d;
  logic                rev_q, rev_d;
  logic [IDX_BITS-1:0] n_q, n_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                done_q, done_d;
  logic [7:0]          rcon_cur;
  logic                is_last;
  logic                xfer;
  key_size_t           ks;

  assign ks      = decode_key_size(key_size);
  assign valid   = (state_q == RUN);
  assign xfer    = valid && next;
  assign is_last = valid && (rev_q ? (idx_q == IDX_BITS'(1)) : (idx_q == n_q));

`ifdef RCON_SEQ_ROM_EN
  localparam logic [7:0] RCON_ROM [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };
  logic [IDX_BITS-1:0] rom_addr;

  assign rom_addr = idx_q - IDX_BITS'(1);

  // Table lookup by round index; out-of-range addresses only occur while idle
  always_comb begin
    rcon_cur = 8'h00;
    if (rom_addr < IDX_BITS'(10)) begin
      rcon_cur = RCON_ROM[rom_addr[3:0]];
    end
  end
`else
  logic [7:0] rcon_q, rcon_d;
  logic [7:0] rcon_step;

  gf_xtime u_xtime (
    .r      (rcon_q),
    .dir    (rev_q),
    .r_next (rcon_step)
  );

  assign rcon_cur = rcon_q;

  // Constant register: seeded on start, stepped on each non-final transfer
  always_comb begin
    rcon_d = rcon_q;
    if (start) begin
      rcon_d = reverse ? rcon_last(ks) : 8'h01;
    end else if (xfer && !is_last) begin
      rcon_d = rcon_step;
    end
  end

  // Constant register state
  always_ff @(posedge clk) begin
    if (rst) begin
      rcon_q <= 8'h01;
    end else begin
      rcon_q <= rcon_d;
    end
  end
`endif

  // Next-state: start restarts from any state and wins over a simultaneous transfer
  always_comb begin
    state_d = state_q;
    rev_d   = rev_q;
    n_d     = n_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = RUN;
      rev_d   = reverse;
      n_d     = IDX_BITS'(rcon_rounds(ks));
      idx_d   = reverse ? IDX_BITS'(rcon_rounds(ks)) : IDX_BITS'(1);
    end else if (xfer) begin
      if (is_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d = rev_q ? (idx_q - IDX_BITS'(1)) : (idx_q + IDX_BITS'(1));
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rev_q   <= 1'b0;
      n_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rev_q   <= rev_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Data outputs are forced to zero whenever no constant is being offered
  always_comb begin
    readData = '0;
    index    = '0;
    if (valid) begin
      readData = BITS'(rcon_cur) << (BITS - 8);
      index    = idx_q;
    end
  end

  assign last = is_last;
  assign busy = valid;
  assign done = done_q;

endmodule
